// File: rtl/dac_sweep_ctrl_if.sv
// Command bus between the sweep sequencer and the signal generator.
// The master drives opcode/address/data with a valid flag and the slave accepts with ready.
`timescale 1ns/1ps

interface dac_sweep_ctrl_if;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    modport master (
        output cmd_opcode,
        output cmd_addr,
        output cmd_data,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_opcode,
        input  cmd_addr,
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/dac_sweep_ctrl.sv
// Frequency-sweep sequencer for the analog signal generator.
// Enables the generator output, then steps the frequency word from start to stop.
// Each step is held for a dwell time. Sweeps run once or continuously, and can be aborted.
// After a sweep ends the output is disabled again.
`timescale 1ns/1ps

module dac_sweep_ctrl #(
    parameter int unsigned DWELL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cfg_start_freq,
    input  logic [31:0]        cfg_stop_freq,
    input  logic [31:0]        cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic               start,
    input  logic               abort,
    dac_sweep_ctrl_if.master   cmd,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        cur_freq
);

    localparam logic [7:0] OP_ENABLE = 8'h36;
    localparam logic [7:0] OP_FREQ   = 8'h32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN_ON,
        S_SET_F,
        S_DWELL,
        S_EN_OFF
    } state_t;

    state_t             state_q, state_d;
    logic               vld_q, vld_d;
    logic [7:0]         op_q, op_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        freq_q, freq_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        start_q, start_d;
    logic [31:0]        stop_q, stop_d;
    logic [31:0]        step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;

    logic               accept;
    logic [32:0]        step_sum;

    assign accept   = vld_q & cmd.cmd_ready;
    // A carry out of bit 31 makes the sum exceed any 32-bit stop value.
    // This means a frequency overflow is treated as being past the stop value.
    assign step_sum = {1'b0, freq_q} + {1'b0, step_q};

    assign cmd.cmd_opcode = op_q;
    assign cmd.cmd_addr   = '0;
    assign cmd.cmd_data   = data_q;
    assign cmd.cmd_valid  = vld_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign cur_freq       = freq_q;

    // Next-state, command issue and sweep arithmetic.
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        op_d    = op_q;
        data_d  = data_q;
        freq_d  = freq_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if ((cfg_step == '0) || (cfg_start_freq > cfg_stop_freq)) begin
                        err_d = 1'b1;
                    end else begin
                        start_d = cfg_start_freq;
                        stop_d  = cfg_stop_freq;
                        step_d  = cfg_step;
                        dwell_d = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                        cont_d  = cfg_continuous;
                        state_d = S_EN_ON;
                        vld_d   = 1'b1;
                        op_d    = OP_ENABLE;
                        data_d  = 32'd1;
                    end
                end
            end

            // A command is always pending in this state, so an abort is held until the command completes.
            S_EN_ON: begin
                if (abort) abort_d = 1'b1;
                if (accept) begin
                    if (abort_q || abort) begin
                        state_d = S_EN_OFF;
                        op_d    = OP_ENABLE;
                        data_d  = '0;
                    end else begin
                        state_d = S_SET_F;
                        op_d    = OP_FREQ;
                        data_d  = start_q;
                        freq_d  = start_q;
                    end
                end
            end

            S_SET_F: begin
                if (abort) abort_d = 1'b1;
                if (accept) begin
                    if (abort_q || abort) begin
                        state_d = S_EN_OFF;
                        op_d    = OP_ENABLE;
                        data_d  = '0;
                    end else begin
                        state_d = S_DWELL;
                        vld_d   = 1'b0;
                        cnt_d   = dwell_q;
                    end
                end
            end

            // The frequency decision is made in the cycle where the counter reaches 1.
            // This keeps frequency commands dwell+1 cycles apart.
            S_DWELL: begin
                if (abort) begin
                    state_d = S_EN_OFF;
                    vld_d   = 1'b1;
                    op_d    = OP_ENABLE;
                    data_d  = '0;
                end else if (cnt_q <= DWELL_W'(1)) begin
                    if (step_sum <= {1'b0, stop_q}) begin
                        state_d = S_SET_F;
                        vld_d   = 1'b1;
                        op_d    = OP_FREQ;
                        data_d  = step_sum[31:0];
                        freq_d  = step_sum[31:0];
                    end else if (cont_q) begin
                        state_d = S_SET_F;
                        vld_d   = 1'b1;
                        op_d    = OP_FREQ;
                        data_d  = start_q;
                        freq_d  = start_q;
                    end else begin
                        state_d = S_EN_OFF;
                        vld_d   = 1'b1;
                        op_d    = OP_ENABLE;
                        data_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end

            S_EN_OFF: begin
                if (accept) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                    abort_d = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything without sending a disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
            op_q    <= '0;
            data_q  <= '0;
            freq_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            op_q    <= op_d;
            data_q  <= data_d;
            freq_q  <= freq_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
        end
    end

endmodule
